icache_dm: RTL and testbench
============================

// Module: icache_dm
// PURPOSE
//  Direct-mapped, read-only instruction cache between the single-cycle MIPS fetch port and a slow
//  block-wide instruction memory. It serves a hit in the same cycle. On a miss it stalls the core,
//  fetches a 4-word block and refills the line. It then serves the access on the cycle after the refill.
// PARAMETERS
//  NUM_LINES   8    number of cache lines; power of 2, >=2
//  IDX_W       3    log2(NUM_LINES); must be consistent with NUM_LINES
// PORTS
//  clk          in   1    rising-edge clock
//  rst_n        in   1    synchronous active-low reset, sampled on rising clk
//  proc_read    in   1    fetch request valid
//  proc_addr    in   30   word address (byte addr [31:2]); [1:0]=word-in-block
//  proc_rdata   out  32   instruction word; valid when proc_read && !proc_stall
//  proc_stall   out  1    core must hold PC/proc_addr while high
//  mem_read     out  1    block read request to memory
//  mem_addr     out  28   block address (proc_addr[29:2])
//  mem_rdata    in   128  block data; word0 in [31:0], word3 in [127:96]
//  mem_ready    in   1    one-cycle pulse; mem_rdata valid in that cycle
//  hit_cnt      out  32   (ICACHE_STATS_EN only) hit counter
//  miss_cnt     out  32   (ICACHE_STATS_EN only) miss counter
// BEHAVIOUR
//  Address split: offset=proc_addr[1:0], index=proc_addr[IDX_W+1:2], tag=proc_addr[29:IDX_W+2].
//  Per line state: valid bit, tag, 4x32 data. Data/tag arrays are plain registers, not reset.
//  Reset: all valid=0, state=IDLE, mem_read=0, mem_addr=0, proc_stall=0, proc_rdata=0, counters=0.
//  FSM: IDLE, FETCH, which is encoded in 1 bit.
//   IDLE:
//    - proc_read=0: proc_stall=0, proc_rdata=0, no state change.
//    - hit (valid && tag match): proc_stall=0; proc_rdata = selected word, combinational from the arrays.
//    - miss: proc_stall=1, combinational in the same cycle.
//      Register miss_addr=proc_addr[29:2]. Go to FETCH.
//   FETCH:
//    - mem_read=1; mem_addr=miss_addr, held stable until the mem_ready cycle; proc_stall=1.
//    - On mem_ready: write mem_rdata, tag and valid=1 to the line; next state IDLE; mem_read=0 next cycle.
//    - The re-presented address then hits in IDLE.
//  Miss penalty: N+1 stall cycles, where N = cycles from mem_read rising to mem_ready inclusive.
//  mem_ready outside FETCH: ignored.
//  mem_read and mem_addr are registered outputs. There is no combinational path from proc_* to mem_*.
//  proc_addr changing during FETCH: illegal. The refill still targets miss_addr.
//  proc_read dropping during FETCH: the fetch completes and the line is filled; no response.
//  Reset asserted mid-FETCH: abandon the fetch.
//   - mem_read=0 and all valid=0 from the next cycle.
//   - A later mem_ready for the abandoned fetch is ignored.
//  A miss replaces the existing line unconditionally. There is no write path and no coherence.
// CONFIGURATION
//  ICACHE_STATS_EN defined:
//   - hit_cnt increments on each IDLE hit with proc_read=1.
//   - miss_cnt increments on each IDLE->FETCH transition.
//   - Both counters saturate at 32'hFFFF_FFFF and are cleared by reset.
//  ICACHE_STATS_EN undefined: the hit_cnt and miss_cnt ports and their logic are absent.
//   Functional behaviour is otherwise identical.
// STRUCTURE
//  Shared package mips_pkg:
//   - opcode/width constants: WORD_W=32, BLOCK_W=128, WORDS_PER_BLOCK=4.
//   - icache FSM state enum {IC_IDLE, IC_FETCH}.
//  One sub-module, icache_line_array: valid/tag/data storage.
//   - Combinational read port by index.
//   - Single write port driven on the refill cycle.
//   - valid clear on reset.
//  The FSM, the hit compare and the stall logic stay in icache_dm.
// TESTING (memory model: mem_ready asserted 3 cycles after mem_read rises unless stated)
//  1 Cold miss:
//    stimulus: after reset, proc_read=1, proc_addr=30'h0000_0004.
//    required: proc_stall=1 in the same cycle; mem_read=1 with mem_addr=28'h1 next cycle;
//    4 stall cycles in total; then proc_rdata = word0 of the block; hit_cnt=1, miss_cnt=1.
//  2 Sequential hits:
//    stimulus: after test 1, present addresses 30'h5, 30'h6 and 30'h7.
//    required: proc_stall=0 for each; proc_rdata = mem_rdata words 1, 2 and 3; mem_read stays 0.
//  3 Conflict eviction (NUM_LINES=8):
//    stimulus: address 30'h4 cached; access 30'h24, which has the same index and a different tag.
//    required: a miss and a refill; a re-access of 30'h4 misses again.
//  4 Reset mid-FETCH:
//    stimulus: assert rst_n=0 for 1 cycle while mem_read=1; pulse mem_ready 2 cycles later.
//    required: mem_read=0 after reset; no line becomes valid; the next access to that address misses.
//  5 Idle and stray ready:
//    stimulus: proc_read=0 with a mem_ready pulse in IDLE.
//    required: proc_stall=0, proc_rdata=0, no valid bit changes, counters unchanged.
//  6 Zero-wait memory:
//    stimulus: mem_ready asserted in the first FETCH cycle.
//    required: a stall of exactly 2 cycles, then a correct hit.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS-side constants and the instruction-cache FSM state type.
package mips_pkg;

    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = 128;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int PADDR_W         = 30;
    localparam int BADDR_W         = 28;

    typedef enum logic {
        IC_IDLE  = 1'b0,
        IC_FETCH = 1'b1
    } ic_state_t;

    // Word 0 sits in the low 32 bits of a block.
    function automatic logic [WORD_W-1:0] word_sel(input logic [BLOCK_W-1:0] blk,
                                                   input logic [1:0]         off);
        return blk[32'(off) * WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/icache_dm_if.sv
// Fetch-port and block-memory bus bundles for the direct-mapped instruction cache.
interface icache_proc_if;
    import mips_pkg::*;

    logic                 read;
    logic [PADDR_W-1:0]   addr;
    logic [WORD_W-1:0]    rdata;
    logic                 stall;

    modport master (output read, addr, input rdata, stall);
    modport slave  (input read, addr, output rdata, stall);
endinterface

interface icache_mem_if;
    import mips_pkg::*;

    logic                 read;
    logic [BADDR_W-1:0]   addr;
    logic [BLOCK_W-1:0]   rdata;
    logic                 ready;

    modport master (output read, addr, input rdata, ready);
    modport slave  (input read, addr, output rdata, ready);
endinterface

// File: rtl/icache_dm_line_array.sv
// Valid/tag/data storage for the cache: combinational read by index, one refill write port.
module icache_line_array
    import mips_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int IDX_W     = 3,
    parameter int TAG_W     = BADDR_W - IDX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IDX_W-1:0]   ridx,
    output logic               rvalid,
    output logic [TAG_W-1:0]   rtag,
    output logic [BLOCK_W-1:0] rdata,
    input  logic               we,
    input  logic [IDX_W-1:0]   widx,
    input  logic [TAG_W-1:0]   wtag,
    input  logic [BLOCK_W-1:0] wdata
);

    logic [NUM_LINES-1:0] valid;
    logic [TAG_W-1:0]     tags  [NUM_LINES];
    logic [BLOCK_W-1:0]   blocks[NUM_LINES];

    // Only the valid bits are reset; tag/data are qualified by valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (we) begin
            valid[widx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tags[widx]   <= wtag;
            blocks[widx] <= wdata;
        end
    end

    assign rvalid = valid[ridx];
    assign rtag   = tags[ridx];
    assign rdata  = blocks[ridx];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with single-cycle hits and 4-word block refill.
// Define ICACHE_STATS_EN to add saturating hit_cnt/miss_cnt outputs.
//
// state    | meaning
// IC_IDLE  | serve hits combinationally; a miss stalls and launches a block read
// IC_FETCH | mem_read held high on miss_addr until mem_ready, then refill the line
module icache_dm
    import mips_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int IDX_W     = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    icache_proc_if.slave proc,
    icache_mem_if.master mem
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]  hit_cnt,
    output logic [31:0]  miss_cnt
`endif
);

    localparam int TAG_W = BADDR_W - IDX_W;

    if (NUM_LINES != (1 << IDX_W)) begin : g_bad_params
        $error("icache_dm: NUM_LINES must equal 2**IDX_W");
    end

    ic_state_t            state;
    ic_state_t            state_nx;
    logic [BADDR_W-1:0]   miss_addr;
    logic                 mem_read;

    logic [IDX_W-1:0]     idx;
    logic [TAG_W-1:0]     tag;
    logic [1:0]           off;

    logic                 line_valid;
    logic [TAG_W-1:0]     line_tag;
    logic [BLOCK_W-1:0]   line_data;
    logic                 hit;

    logic                 stall;
    logic [WORD_W-1:0]    rdata;
    logic                 miss_start;
    logic                 refill;

    assign off = proc.addr[1:0];
    assign idx = proc.addr[IDX_W+1:2];
    assign tag = proc.addr[PADDR_W-1:IDX_W+2];

    icache_line_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_lines (
        .clk    (clk),
        .rst_n  (rst_n),
        .ridx   (idx),
        .rvalid (line_valid),
        .rtag   (line_tag),
        .rdata  (line_data),
        .we     (refill),
        .widx   (miss_addr[IDX_W-1:0]),
        .wtag   (miss_addr[BADDR_W-1:IDX_W]),
        .wdata  (mem.rdata)
    );

    assign hit = line_valid && (line_tag == tag);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IC_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        stall      = 1'b0;
        rdata      = '0;
        miss_start = 1'b0;
        refill     = 1'b0;
        case (state)
            IC_IDLE: begin
                if (proc.read) begin
                    if (hit) begin
                        rdata = word_sel(line_data, off);
                    end else begin
                        stall      = 1'b1;
                        miss_start = 1'b1;
                        state_nx   = IC_FETCH;
                    end
                end
            end
            IC_FETCH: begin
                stall = 1'b1;
                if (mem.ready) begin
                    refill   = 1'b1;
                    state_nx = IC_IDLE;
                end
            end
            default: state_nx = IC_IDLE;
        endcase
    end

    // mem_* are launched from flops so no fetch-port path reaches the memory bus.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_read  <= 1'b0;
            miss_addr <= '0;
        end else if (miss_start) begin
            mem_read  <= 1'b1;
            miss_addr <= proc.addr[PADDR_W-1:2];
        end else if (refill) begin
            mem_read  <= 1'b0;
        end
    end

    assign mem.read   = mem_read;
    assign mem.addr   = miss_addr;
    assign proc.stall = stall;
    assign proc.rdata = rdata;

`ifdef ICACHE_STATS_EN
    logic hit_ev;
    assign hit_ev = (state == IC_IDLE) && proc.read && hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit_ev && (hit_cnt != 32'hFFFF_FFFF)) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (miss_start && (miss_cnt != 32'hFFFF_FFFF)) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Randomized self-checking bench for icache_dm against a line-level reference model.
module tb_icache_dm;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    icache_proc_if proc_bus ();
    icache_mem_if  mem_bus ();

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    icache_dm #(
        .NUM_LINES (8),
        .IDX_W     (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .proc     (proc_bus),
        .mem      (mem_bus)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- memory model ----------------
    logic [31:0]  salt;
    bit           mem_auto = 1'b1;
    int           mem_lat  = 3;
    bit           stray_req = 1'b0;
    logic [127:0] stray_data = '0;
    int           mem_cnt = 0;

    function automatic logic [31:0] word_of(input logic [29:0] wa);
        logic [31:0] x;
        x = {2'b00, wa};
        return (x * 32'h9E37_79B1) ^ salt ^ {wa[15:0], wa[29:14]};
    endfunction

    function automatic logic [127:0] block_of(input logic [27:0] ba);
        return {word_of({ba, 2'd3}), word_of({ba, 2'd2}),
                word_of({ba, 2'd1}), word_of({ba, 2'd0})};
    endfunction

    initial begin : mem_model
        mem_bus.ready = 1'b0;
        mem_bus.rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_auto && mem_bus.read) mem_cnt++;
            else mem_cnt = 0;
            if (stray_req) begin
                mem_bus.ready = 1'b1;
                mem_bus.rdata = stray_data;
            end else if (mem_auto && mem_bus.read && mem_cnt == mem_lat) begin
                mem_bus.ready = 1'b1;
                mem_bus.rdata = block_of(mem_bus.addr);
            end else begin
                mem_bus.ready = 1'b0;
                mem_bus.rdata = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    // ---------------- reference model ----------------
    bit          ref_valid[8];
    logic [24:0] ref_tag[8];
    int          ref_hits = 0;
    int          ref_misses = 0;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
        ref_hits   = 0;
        ref_misses = 0;
    endtask

    task automatic check_counters(input string tag);
`ifdef ICACHE_STATS_EN
        chk({tag, "_hit_cnt"}, hit_cnt, ref_hits);
        chk({tag, "_miss_cnt"}, miss_cnt, ref_misses);
`else
        chk({tag, "_stall_idle"}, proc_bus.stall, 1'b0);
`endif
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
        proc_bus.read = 1'b0;
        proc_bus.addr = 30'($urandom);
        @(negedge clk);
        chk("idle_stall", proc_bus.stall, 1'b0);
        chk("idle_rdata", proc_bus.rdata, 32'h0);
    endtask

    // One fetch: expected hit/miss and miss penalty come from the model.
    task automatic access(input logic [29:0] a);
        int          idx;
        logic [24:0] t;
        bit          exp_hit;
        int          exp_stalls;
        int          stalls;
        idx        = int'(a[4:2]);
        t          = a[29:5];
        exp_hit    = ref_valid[idx] && (ref_tag[idx] == t);
        exp_stalls = exp_hit ? 0 : mem_lat + 1;
        @(posedge clk);
        #1;
        proc_bus.read = 1'b1;
        proc_bus.addr = a;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (!proc_bus.stall) break;
            if (stalls == 1) begin
                chk("fetch_mem_read", mem_bus.read, 1'b1);
                chk("fetch_mem_addr", mem_bus.addr, a[29:2]);
            end
            stalls++;
            if (stalls > 40) break;
            @(posedge clk);
            #1;
        end
        chk("stall_cycles", stalls, exp_stalls);
        chk("rdata", proc_bus.rdata, word_of(a));
        chk("served_mem_read", mem_bus.read, 1'b0);
        ref_valid[idx] = 1'b1;
        ref_tag[idx]   = t;
        ref_hits++;
        if (!exp_hit) ref_misses++;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    logic [29:0] addr_a;
    logic [29:0] ra;

    initial begin : main
        salt          = $urandom;
        proc_bus.read = 1'b0;
        proc_bus.addr = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_stall", proc_bus.stall, 1'b0);
        chk("rst_rdata", proc_bus.rdata, 32'h0);
        chk("rst_mem_read", mem_bus.read, 1'b0);
        chk("rst_mem_addr", mem_bus.addr, 28'h0);
        check_counters("rst");

        // cold miss, then sequential hits in the same block
        mem_lat = 3;
        access(30'h0000_0004);
        idle_cycle();
        check_counters("cold");
        access(30'h5);
        access(30'h6);
        access(30'h7);

        // conflict eviction on index 1
        access(30'h24);
        access(30'h4);
        idle_cycle();
        check_counters("evict");

        // reset in the middle of a fetch, with the abandoned ready arriving late
        mem_auto = 1'b0;
        addr_a   = 30'h0000_1230;
        @(posedge clk);
        #1;
        proc_bus.read = 1'b1;
        proc_bus.addr = addr_a;
        @(negedge clk);
        chk("rmf_stall0", proc_bus.stall, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rmf_mem_read", mem_bus.read, 1'b1);
        @(posedge clk);
        #1;
        rst_n         = 1'b0;
        proc_bus.read = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        chk("rmf_mem_read_off", mem_bus.read, 1'b0);
        chk("rmf_mem_addr", mem_bus.addr, 28'h0);
        chk("rmf_stall_off", proc_bus.stall, 1'b0);
        stray_req  = 1'b1;
        stray_data = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rmf_late_stall", proc_bus.stall, 1'b0);
        chk("rmf_late_rdata", proc_bus.rdata, 32'h0);
        chk("rmf_late_mem_read", mem_bus.read, 1'b0);
        stray_req = 1'b0;
        idle_cycle();
        check_counters("rmf");
        mem_auto = 1'b1;
        access(addr_a);
        access(30'h4);

        // stray ready while idle must not touch any line
        idle_cycle();
        stray_req  = 1'b1;
        stray_data = {$urandom, $urandom, $urandom, $urandom};
        idle_cycle();
        stray_req = 1'b0;
        idle_cycle();
        check_counters("stray");
        access(30'h4);
        access(addr_a);

        // zero-wait memory
        mem_lat = 1;
        access(30'h3FF0_0012);
        access(30'h3FF0_0011);

        // random traffic over a small tag pool to force hits and conflicts
        repeat (80) begin
            mem_lat = $urandom_range(1, 4);
            ra = {25'($urandom_range(0, 3)) ^ 25'h0155, 3'($urandom_range(0, 7)),
                  2'($urandom_range(0, 3))};
            access(ra);
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();
        check_counters("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
